// File: rtl/game_collision_scan.sv
// Sequential pairwise bounding-box collision scanner: one object pair per clock over a start-time snapshot.
// Optional first-colliding-pair outputs are enabled by defining GAME_COLLISION_SCAN_PAIR_ID_EN.
module game_collision_scan #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10,
    parameter int N_OBJ   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [N_OBJ-1:0]           active,
    input  logic [N_OBJ*X_WIDTH-1:0]   left,
    input  logic [N_OBJ*X_WIDTH-1:0]   right,
    input  logic [N_OBJ*Y_WIDTH-1:0]   top,
    input  logic [N_OBJ*Y_WIDTH-1:0]   bottom,
    output logic                       busy,
    output logic                       done,
    output logic [N_OBJ-1:0]           hit_mask,
    output logic                       any_hit
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
    ,
    output logic [2:0]                 first_a,
    output logic [2:0]                 first_b,
    output logic                       first_valid
`endif
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [2:0] LAST_I = 3'(N_OBJ - 2);
    localparam logic [2:0] LAST_J = 3'(N_OBJ - 1);

    state_t                   state, state_next;
    logic [2:0]               idx_i, idx_j;
    logic                     load, last_pair;

    logic [N_OBJ-1:0]         snap_active;
    logic [N_OBJ*X_WIDTH-1:0] snap_left, snap_right;
    logic [N_OBJ*Y_WIDTH-1:0] snap_top, snap_bottom;
    logic [N_OBJ-1:0]         work_mask, mask_next, pair_bits;
    logic [N_OBJ-1:0]         act_i, act_j;
    logic [X_WIDTH-1:0]       la, ra, lb, rb;
    logic [Y_WIDTH-1:0]       ta, ba, tb, bb;
    logic                     pair_hit;

    // An inverted box (left>right or top>bottom) is treated as empty and never overlaps.
    function automatic logic overlap(
        input logic [X_WIDTH-1:0] l0, r0, l1, r1,
        input logic [Y_WIDTH-1:0] t0, b0, t1, b1
    );
        return (l0 <= r0) && (t0 <= b0) && (l1 <= r1) && (t1 <= b1) &&
               (l0 <= r1) && (l1 <= r0) && (t0 <= b1) && (t1 <= b0);
    endfunction

    assign la = snap_left  [idx_i*X_WIDTH +: X_WIDTH];
    assign ra = snap_right [idx_i*X_WIDTH +: X_WIDTH];
    assign lb = snap_left  [idx_j*X_WIDTH +: X_WIDTH];
    assign rb = snap_right [idx_j*X_WIDTH +: X_WIDTH];
    assign ta = snap_top   [idx_i*Y_WIDTH +: Y_WIDTH];
    assign ba = snap_bottom[idx_i*Y_WIDTH +: Y_WIDTH];
    assign tb = snap_top   [idx_j*Y_WIDTH +: Y_WIDTH];
    assign bb = snap_bottom[idx_j*Y_WIDTH +: Y_WIDTH];

    assign act_i     = snap_active >> idx_i;
    assign act_j     = snap_active >> idx_j;
    assign pair_hit  = act_i[0] && act_j[0] && overlap(la, ra, lb, rb, ta, ba, tb, bb);
    assign pair_bits = (N_OBJ'(1) << idx_i) | (N_OBJ'(1) << idx_j);
    assign mask_next = work_mask | (pair_hit ? pair_bits : '0);

    assign busy    = (state == SCAN);
    assign any_hit = |hit_mask;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        last_pair  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (idx_i == LAST_I && idx_j == LAST_J) begin
                    last_pair  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
    logic       work_fv, fv_next;
    logic [2:0] work_fa, work_fb, fa_next, fb_next;

    // The earliest hit in scan order wins; later hits never overwrite it.
    assign fv_next = work_fv | pair_hit;
    assign fa_next = work_fv ? work_fa : (pair_hit ? idx_i : 3'd0);
    assign fb_next = work_fv ? work_fb : (pair_hit ? idx_j : 3'd0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx_i    <= 3'd0;
            idx_j    <= 3'd1;
            done     <= 1'b0;
            hit_mask <= '0;
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
            first_valid <= 1'b0;
            first_a     <= 3'd0;
            first_b     <= 3'd0;
`endif
        end else begin
            state <= state_next;
            done  <= last_pair;
            if (load) begin
                idx_i <= 3'd0;
                idx_j <= 3'd1;
            end else if (state == SCAN && !last_pair) begin
                if (idx_j == LAST_J) begin
                    idx_i <= idx_i + 3'd1;
                    idx_j <= idx_i + 3'd2;
                end else begin
                    idx_j <= idx_j + 3'd1;
                end
            end
            if (last_pair) begin
                hit_mask <= mask_next;
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
                first_valid <= fv_next;
                first_a     <= fa_next;
                first_b     <= fb_next;
`endif
            end
        end
    end

    // Snapshot and working accumulators: datapath only, always initialised by load.
    always_ff @(posedge clk) begin
        if (load) begin
            snap_active <= active;
            snap_left   <= left;
            snap_right  <= right;
            snap_top    <= top;
            snap_bottom <= bottom;
            work_mask   <= '0;
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
            work_fv <= 1'b0;
            work_fa <= 3'd0;
            work_fb <= 3'd0;
`endif
        end else if (state == SCAN) begin
            work_mask <= mask_next;
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
            work_fv <= fv_next;
            work_fa <= fa_next;
            work_fb <= fb_next;
`endif
        end
    end

endmodule

// File: tb/tb_game_collision_scan.sv
// Directed self-checking bench for game_collision_scan with N_OBJ=4 (six pairs per scan).
module tb_game_collision_scan;

    localparam int XW = 10;
    localparam int YW = 10;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [N-1:0]    active;
    logic [N*XW-1:0] left, right;
    logic [N*YW-1:0] top, bottom;
    logic            busy, done, any_hit;
    logic [N-1:0]    hit_mask;
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
    logic [2:0]      first_a, first_b;
    logic            first_valid;
`endif

    int errors = 0;
    int checks = 0;

    game_collision_scan #(.X_WIDTH(XW), .Y_WIDTH(YW), .N_OBJ(N)) dut (
        .clk(clk), .reset(reset), .start(start), .active(active),
        .left(left), .right(right), .top(top), .bottom(bottom),
        .busy(busy), .done(done), .hit_mask(hit_mask), .any_hit(any_hit)
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
        , .first_a(first_a), .first_b(first_b), .first_valid(first_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_obj(input int k, input int l, input int r, input int t, input int b);
        left[k*XW +: XW]   = XW'(l);
        right[k*XW +: XW]  = XW'(r);
        top[k*YW +: YW]    = YW'(t);
        bottom[k*YW +: YW] = YW'(b);
    endtask

    task automatic cfg_disjoint();
        for (int k = 0; k < N; k++) set_obj(k, 20*k, 20*k+9, 20*k, 20*k+9);
        active = 4'b1111;
    endtask

    task automatic cfg_shared();
        set_obj(0, 0, 10, 0, 9);
        set_obj(1, 40, 49, 20, 29);
        set_obj(2, 10, 20, 0, 9);
        set_obj(3, 60, 69, 60, 69);
        active = 4'b1111;
    endtask

    // Leaves the caller on the falling edge right after the start edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        cfg_disjoint();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hit_mask !== 4'b0000 || any_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hit=%b any=%b, required 0 0 0000 0", busy, done, hit_mask, any_hit);
        end
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
        checks++;
        if (first_valid !== 1'b0 || first_a !== 3'd0 || first_b !== 3'd0) begin
            errors++;
            $display("FAIL reset_first: v=%b a=%0d b=%0d, required 0 0 0", first_valid, first_a, first_b);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_disjoint();
        int lat = 0;
        cfg_disjoint();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL disjoint_busy: busy=%b, required 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL disjoint_latency: %0d cycles, required 6", lat);
        end
        checks++;
        if (hit_mask !== 4'b0000 || any_hit !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL disjoint_result: hit=%b any=%b busy=%b, required 0000 0 0", hit_mask, any_hit, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_cycle: done=%b, required 0", done);
        end
    endtask

    task automatic test_inactive();
        int lat = 0;
        cfg_shared();
        active = 4'b1011;
        pulse_start();
        wait_done(lat);
        checks++;
        if (lat != 6 || hit_mask !== 4'b0000 || any_hit !== 1'b0) begin
            errors++;
            $display("FAIL inactive_mask: lat=%0d hit=%b any=%b, required 6 0000 0", lat, hit_mask, any_hit);
        end
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
        checks++;
        if (first_valid !== 1'b0 || first_a !== 3'd0 || first_b !== 3'd0) begin
            errors++;
            $display("FAIL inactive_first: v=%b a=%0d b=%0d, required 0 0 0", first_valid, first_a, first_b);
        end
`endif
    endtask

    task automatic test_shared_edge();
        int lat = 0;
        cfg_shared();
        pulse_start();
        wait_done(lat);
        checks++;
        if (lat != 6 || hit_mask !== 4'b0101 || any_hit !== 1'b1) begin
            errors++;
            $display("FAIL shared_edge: lat=%0d hit=%b any=%b, required 6 0101 1", lat, hit_mask, any_hit);
        end
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
        checks++;
        if (first_valid !== 1'b1 || first_a !== 3'd0 || first_b !== 3'd2) begin
            errors++;
            $display("FAIL shared_first: v=%b a=%0d b=%0d, required 1 0 2", first_valid, first_a, first_b);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        bit unstable = 0;
        cfg_disjoint();
        pulse_start();
        set_obj(3, 20, 29, 20, 29);
        while (!done && lat < 20) begin
            if (hit_mask !== 4'b0101) unstable = 1;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL hold_during_scan: hit=%b changed, required 0101 held", hit_mask);
        end
        checks++;
        if (lat != 6 || hit_mask !== 4'b0000) begin
            errors++;
            $display("FAIL snapshot_isolation: lat=%0d hit=%b, required 6 0000", lat, hit_mask);
        end
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
        end
        lat = 0;
        wait_done(lat);
        checks++;
        if (lat != 6 || hit_mask !== 4'b1010 || any_hit !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d hit=%b any=%b, required 6 1010 1", lat, hit_mask, any_hit);
        end
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
        checks++;
        if (first_valid !== 1'b1 || first_a !== 3'd1 || first_b !== 3'd3) begin
            errors++;
            $display("FAIL b2b_first: v=%b a=%0d b=%0d, required 1 1 3", first_valid, first_a, first_b);
        end
`endif
    endtask

    task automatic test_reset_mid_scan();
        int lat = 0;
        bit spurious = 0;
        cfg_disjoint();
        set_obj(3, 20, 29, 20, 29);
        pulse_start();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hit_mask !== 4'b0000 || any_hit !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b hit=%b any=%b, required 0 0 0000 0", busy, done, hit_mask, any_hit);
        end
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
        checks++;
        if (first_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_first: v=%b, required 0", first_valid);
        end
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious = 1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL abort_no_done: done/busy seen high after abort, required 0");
        end
        pulse_start();
        wait_done(lat);
        checks++;
        if (lat != 6 || hit_mask !== 4'b1010) begin
            errors++;
            $display("FAIL restart_after_reset: lat=%0d hit=%b, required 6 1010", lat, hit_mask);
        end
    endtask

    task automatic test_inverted();
        int lat = 0;
        set_obj(0, 30, 5, 0, 100);
        set_obj(1, 0, 9, 0, 9);
        set_obj(2, 20, 29, 20, 29);
        set_obj(3, 25, 35, 25, 35);
        active = 4'b1111;
        pulse_start();
        wait_done(lat);
        checks++;
        if (lat != 6 || hit_mask !== 4'b1100) begin
            errors++;
            $display("FAIL inverted_box: lat=%0d hit=%b, required 6 1100", lat, hit_mask);
        end
`ifdef GAME_COLLISION_SCAN_PAIR_ID_EN
        checks++;
        if (first_valid !== 1'b1 || first_a !== 3'd2 || first_b !== 3'd3) begin
            errors++;
            $display("FAIL inverted_first: v=%b a=%0d b=%0d, required 1 2 3", first_valid, first_a, first_b);
        end
`endif
    endtask

    task automatic test_start_ignored();
        int lat = 0;
        bit extra = 0;
        cfg_disjoint();
        pulse_start();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        wait_done(lat);
        checks++;
        if (lat != 6 || hit_mask !== 4'b0000) begin
            errors++;
            $display("FAIL busy_start_result: lat=%0d hit=%b, required 6 0000", lat, hit_mask);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) extra = 1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL busy_start_queued: second scan observed, required none");
        end
    endtask

    initial begin
        start = 1'b0;
        reset = 1'b1;
        test_reset();
        test_disjoint();
        test_inactive();
        test_shared_edge();
        test_back_to_back();
        test_reset_mid_scan();
        test_inverted();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_collision_scan.md
GAME_COLLISION_SCAN -- requirements
Module: game_collision_scan

Interface
REQ-001 SHALL have parameter X_WIDTH, default 10, meaning the x-coordinate width in bits.
REQ-002 SHALL have parameter Y_WIDTH, default 10, meaning the y-coordinate width in bits.
REQ-003 SHALL have parameter N_OBJ, default 4, meaning the object count, legal range 2..8.
REQ-004 SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: scan request, sampled on rising edge.
REQ-007 SHALL have port active, input, N_OBJ bits: per-object participate mask.
REQ-008 SHALL have port left and port right, inputs, N_OBJ*X_WIDTH bits each: packed x-bounds, object k at bits [k*X_WIDTH +: X_WIDTH].
REQ-009 SHALL have port top and port bottom, inputs, N_OBJ*Y_WIDTH bits each: packed y-bounds, packed the same way.
REQ-010 SHALL have port busy, output, 1 bit: scan in progress.
REQ-011 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port hit_mask, output, N_OBJ bits: bit k set if object k collides with any other object.
REQ-013 SHALL have port any_hit, output, 1 bit: OR of hit_mask.

Function
REQ-014 Coordinates SHALL be unsigned and inclusive; objects a and b overlap iff left_a<=right_b, left_b<=right_a, top_a<=bottom_b and top_b<=bottom_a.
REQ-015 Overlap SHALL also require both active bits set; an object with left>right or top>bottom SHALL never overlap.
REQ-016 States SHALL be IDLE and SCAN; busy=1 exactly in SCAN.
REQ-017 In IDLE, start=1 at an edge SHALL snapshot all bounds and active into internal registers, clear the working mask, set pair (0,1) and go to SCAN.
REQ-018 All comparisons SHALL use the snapshot; input changes during SCAN SHALL have no effect.
REQ-019 In SCAN, each edge SHALL evaluate one pair (i,j), i<j, in order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1), and OR the result into working-mask bits i and j.
REQ-020 The pair count SHALL be P=N_OBJ*(N_OBJ-1)/2 with one pair per cycle and no skipped or repeated pairs.
REQ-021 The edge evaluating the last pair SHALL load hit_mask with the final working mask, assert done for one cycle, and return to IDLE.
REQ-022 done SHALL therefore be high in the cycle starting P edges after the start edge.
REQ-023 hit_mask and any_hit SHALL hold until the next completion and SHALL not change during SCAN.
REQ-024 start while busy SHALL be ignored and SHALL not be queued.
REQ-025 start in the cycle done is high SHALL be accepted, giving back-to-back scans with no idle gap.

Reset
REQ-026 Reset SHALL force IDLE with busy=0, done=0, hit_mask=0 and any_hit=0 immediately, regardless of clk.
REQ-027 Reset mid-scan SHALL abort the scan with no done pulse; the first start after release SHALL begin a full new scan.

Configuration
REQ-028 Macro GAME_COLLISION_SCAN_PAIR_ID_EN defined SHALL add outputs first_a[2:0], first_b[2:0] and first_valid.
REQ-029 With the macro, these outputs SHALL give the first overlapping pair in scan order, updated with hit_mask at completion; first_valid=0 and indices 0 if no hit or after reset.
REQ-030 Without the macro, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification (N_OBJ=4, P=6)
REQ-031 Disjoint objects [0..9],[20..29],[40..49],[60..69] on both axes, all active, start -> done 6 cycles later, hit_mask=0000, any_hit=0.
REQ-032 Obj0=[0..10], obj2=[10..20] on x, equal y -> hit_mask=0101 (shared edge overlaps); with macro first_a=0, first_b=2.
REQ-033 Same as REQ-032 with active=1011 -> hit_mask=0000.
REQ-034 Change obj3 to overlap obj1 one cycle after start -> result unchanged; then start asserted with done -> second scan reports 1010 six cycles later.
REQ-035 Reset asserted at cycle 3 of a scan -> busy, done and hit_mask 0 at once; no done pulse; next start completes in 6 cycles.
REQ-036 Obj0 with left=30, right=5 fully covering others on y -> bit 0 never set.
